// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   op_e    : operation encoding on the op port
//   state_e : FSM state encoding
//   ITER    : number of shift iterations (one result bit per cycle)
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam int ITER = 32;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

  // MULT and DIV are the signed flavours (op bit 0 clear).
  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle of the multiply/divide unit.
//   master : drives start/op/A/B, observes busy/done/div_by_zero/HI/LO
//   slave  : the unit itself
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, op, A, B,
                  input  busy, done, div_by_zero, HI, LO);
  modport slave  (input  start, op, A, B,
                  output busy, done, div_by_zero, HI, LO);
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate.
//   din  : value in
//   neg  : 1 -> dout = -din, 0 -> dout = din
//   dout : value out
// Used both to take operand magnitudes and to restore result signs.
module mdu_sign_fix #(parameter int W = 32) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);
  assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU).
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of mult_div_unit_if (start/op/A/B in,
//           busy/done/div_by_zero/HI/LO out)
// Signed operations work on magnitudes; signs are restored in FIX.
// A divide by zero bypasses the datapath and reports one cycle later.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int W = WIDTH;

  state_e         state;
  logic [5:0]     cnt;
  logic           is_mul;
  logic           res_neg;   // product / quotient sign
  logic           rem_neg;   // remainder follows dividend sign
  logic           dbz_pend;
  logic [W-1:0]   b_mag;
  logic [2*W-1:0] acc;       // mult: {partial hi, multiplier}; div: {rem, quot}
  logic [W-1:0]   hi, lo;
  logic           busy_r, done_r, dbz_r;

  // operand magnitudes, taken straight from the request
  op_e          op_in;
  logic         sgn_in;
  logic [W-1:0] a_mag_in, b_mag_in;

  assign op_in  = op_e'(bus.op);
  assign sgn_in = is_signed_op(op_in);

  mdu_sign_fix #(.W(W)) u_abs_a (.din(bus.A), .neg(sgn_in & bus.A[W-1]), .dout(a_mag_in));
  mdu_sign_fix #(.W(W)) u_abs_b (.din(bus.B), .neg(sgn_in & bus.B[W-1]), .dout(b_mag_in));

  // shift-add step: add multiplicand when the low bit is set, then shift right
  logic [W:0]     add_sum;
  logic [2*W-1:0] mul_next;
  assign add_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, b_mag};
  assign mul_next = acc[0] ? {add_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};

  // restoring divide step; remainder is always < divisor, so the
  // shifted value fits W+1 bits and the difference fits W bits
  logic [W:0]     sh;
  logic           ge;
  logic [W-1:0]   rem_sub;
  logic [2*W-1:0] div_next;
  assign sh       = {acc[2*W-1:W], acc[W-1]};
  assign ge       = (sh >= {1'b0, b_mag});
  assign rem_sub  = sh[W-1:0] - b_mag;
  assign div_next = ge ? {rem_sub, acc[W-2:0], 1'b1} : {sh[W-1:0], acc[W-2:0], 1'b0};

  // result sign correction
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  mdu_sign_fix #(.W(2*W)) u_fix_prod (.din(acc),          .neg(res_neg), .dout(prod_fix));
  mdu_sign_fix #(.W(W))   u_fix_quo  (.din(acc[W-1:0]),   .neg(res_neg), .dout(quo_fix));
  mdu_sign_fix #(.W(W))   u_fix_rem  (.din(acc[2*W-1:W]), .neg(rem_neg), .dout(rem_fix));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_mul   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      dbz_pend <= 1'b0;
      b_mag    <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_r <= 1'b0;
          dbz_r  <= 1'b0;
          state  <= S_IDLE;
          if (dbz_pend) begin
            // divide-by-zero accepted last edge: report it, HI/LO untouched
            dbz_pend <= 1'b0;
            state    <= S_DONE;
            done_r   <= 1'b1;
            dbz_r    <= 1'b1;
          end else if (bus.start) begin
            if (is_div(op_in) && (bus.B == '0)) begin
              dbz_pend <= 1'b1;
            end else begin
              state   <= S_RUN;
              busy_r  <= 1'b1;
              cnt     <= '0;
              acc     <= {{W{1'b0}}, a_mag_in};
              b_mag   <= b_mag_in;
              is_mul  <= ~is_div(op_in);
              res_neg <= sgn_in & (bus.A[W-1] ^ bus.B[W-1]);
              rem_neg <= sgn_in & bus.A[W-1];
            end
          end
        end
        S_RUN: begin
          acc <= is_mul ? mul_next : div_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(ITER - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (is_mul) begin
            {hi, lo} <= prod_fix;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.HI          = hi;
  assign bus.LO          = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table,
// randomized operations against an arithmetic reference model, and
// hand-written ignored-start / reset-abort sequences.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] hm = '0, lm = '0;   // model of HI/LO

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] eh, el;
    logic        dz;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic; divide by zero keeps HI/LO.
  task automatic ref_model(input logic [1:0] op, input logic [31:0] a, b,
                           output logic [31:0] h, l, output logic dz);
    logic [63:0] p;
    longint sa, sb, q, r;
    dz = 1'b0; h = hm; l = lm;
    case (op)
      2'b00: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      2'b10: if (b == 0) dz = 1'b1;
             else begin
               sa = longint'($signed(a)); sb = longint'($signed(b));
               q = sa / sb; r = sa % sb;
               l = q[31:0]; h = r[31:0];
             end
      default: if (b == 0) dz = 1'b1;
               else begin l = a / b; h = a % b; end
    endcase
  endtask

  // One operation: optional idle gap (gap>0 also checks the done pulse ended),
  // start sampled at edge k, then wait for done with a bounded budget.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, b,
                        input logic [31:0] eh, el, input logic dz, input int gap);
    int n; bit bad; int elat;
    elat = dz ? 1 : 33;
    if (gap > 0) begin
      @(negedge clk);
      @(posedge clk); #1;
      chk({name, "_done_cleared"}, {bus.done, bus.busy}, 2'b00);
      repeat (gap - 1) @(negedge clk);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    // scramble inputs: the unit must work from its captured copies
    bus.start = 1'b0; bus.op = 2'($urandom); bus.A = $urandom; bus.B = $urandom;
    n = 0; bad = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy !== (elat > 1) || bus.HI !== hm || bus.LO !== lm || bus.div_by_zero !== 1'b0) bad = 1;
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, n, elat);
    chk({name, "_busy_hold"}, bad, 0);
    chk({name, "_hilo"}, {bus.HI, bus.LO}, {eh, el});
    chk({name, "_dbz_busy"}, {bus.div_by_zero, bus.busy}, {dz, 1'b0});
    hm = eh; lm = el;
  endtask

  initial begin
    logic [31:0] a, b, eh, el;
    logic [1:0]  op;
    logic        dz;
    int n; bit bad;

    vecs[0] = '{"multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{"mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{"divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    vecs[3] = '{"divu_by0", 2'b11, 32'd5, 32'd0, 32'd2, 32'd14, 1'b1};
    vecs[4] = '{"div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[5] = '{"div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0};
    vecs[6] = '{"mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0};
    vecs[7] = '{"div_by0_signed", 2'b10, 32'h80000000, 32'd0, 32'h40000000, 32'h0, 1'b1};
    vecs[8] = '{"div_7_neg2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0};

    reset = 1'b1; bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {bus.busy, bus.done, bus.div_by_zero, bus.HI, bus.LO}, '0);
    @(negedge clk); reset = 1'b0;

    // directed table; alternate back-to-back (start in DONE) and idle gaps
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].eh, vecs[i].el, vecs[i].dz, (i % 2) ? 0 : 2);

    // randomized operations vs. reference model
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        2: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      ref_model(op, a, b, eh, el, dz);
      run_op("rand", op, a, b, eh, el, dz, $urandom_range(0, 1) * $urandom_range(2, 4));
    end

    // start pulse mid-operation must be ignored (a divide-by-zero if taken)
    a = $urandom; b = $urandom;
    ref_model(2'b01, a, b, eh, el, dz);
    @(negedge clk); bus.start = 1'b1; bus.op = 2'b01; bus.A = a; bus.B = b;
    @(posedge clk); #1; bus.start = 1'b0;
    n = 0;
    do begin
      if (n == 4) begin
        @(negedge clk); bus.start = 1'b1; bus.op = 2'b11; bus.A = 32'd9; bus.B = 32'd0;
      end
      @(posedge clk); #1; bus.start = 1'b0;
      n++;
    end while (!bus.done && n < 40);
    chk("ignored_start_latency", n, 33);
    chk("ignored_start_hilo", {bus.HI, bus.LO, bus.div_by_zero}, {eh, el, 1'b0});
    hm = eh; lm = el;

    // reset at k+10 aborts a MULT; no done may follow
    @(negedge clk); bus.start = 1'b1; bus.op = 2'b00; bus.A = $urandom; bus.B = $urandom;
    @(posedge clk); #1; bus.start = 1'b0;
    for (n = 0; n < 9; n++) begin
      if (n == 4) begin @(negedge clk); bus.start = 1'b1; end
      @(posedge clk); #1; bus.start = 1'b0;
    end
    @(negedge clk); reset = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1; reset = 1'b0; bus.start = 1'b0;
    chk("abort_state", {bus.busy, bus.done, bus.div_by_zero, bus.HI, bus.LO}, '0);
    hm = '0; lm = '0;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) bad = 1;
    end
    chk("abort_no_done", bad, 0);
    a = $urandom; b = $urandom_range(1, 1000);
    ref_model(2'b11, a, b, eh, el, dz);
    run_op("after_abort", 2'b11, a, b, eh, el, dz, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request; sampled at rising edge.
REQ-006 Port: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port: A  input  32  first operand, driven from register-file RD1.
REQ-008 Port: B  input  32  second operand, driven from register-file RD2.
REQ-009 Port: busy  output  1  operation in progress.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: div_by_zero  output  1  valid with done; divide with B=0.
REQ-012 Port: HI  output  32  high product / remainder register.
REQ-013 Port: LO  output  32  low product / quotient register.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, FIX, DONE.
REQ-015 start=1 SHALL be accepted only in IDLE or DONE; at acceptance edge k, A, B and op are captured, operands are converted to magnitudes (signed ops only), and state goes to RUN.
REQ-016 start while busy=1 SHALL be ignored; captured operands SHALL NOT change mid-operation.
REQ-017 RUN SHALL last exactly 32 cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide, using a 6-bit iteration counter.
REQ-018 After RUN, FIX SHALL apply sign correction and write HI/LO at edge k+33; state then goes to DONE.
REQ-019 In DONE, done=1 and busy=0 for exactly one cycle; next edge returns to IDLE, or to RUN if start=1.
REQ-020 busy SHALL be 1 in RUN and FIX, and 0 otherwise.
REQ-021 Multiply SHALL write {HI,LO} = full 64-bit product; signed result is negated when sign(A) xor sign(B).
REQ-022 Divide SHALL write LO = quotient and HI = remainder; signed quotient sign = sign(A) xor sign(B), remainder sign = sign(A).
REQ-023 Unsigned magnitudes SHALL be 32-bit, so abs(0x80000000) = 0x80000000 with no overflow.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0.
REQ-025 Divide with B=0 SHALL skip RUN and FIX: DONE is reached at edge k+1, HI/LO are unchanged, and div_by_zero=1 with done.
REQ-026 div_by_zero SHALL be 0 whenever done=0.
REQ-027 HI/LO SHALL hold their value between operations and change only at FIX or reset.

Reset
REQ-028 When reset=1 at a rising edge: state=IDLE, HI=0, LO=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-029 Reset SHALL override start and abort any operation in progress; no done pulse follows an aborted operation.

Structure
REQ-030 A shared package SHALL hold the op encodings, the FSM state encoding and the constant ITER=32.
REQ-031 One sub-module, mdu_sign_fix (conditional two's-complement negate), SHALL be used for operand magnitude and result correction; the iteration datapath stays in mult_div_unit.

Verification
REQ-032 MULTU A=0xFFFFFFFF B=0xFFFFFFFF, start at edge k -> at edge k+33 HI=0xFFFFFFFE and LO=0x00000001; done=1 for one cycle; busy=1 from k+1 to k+33.
REQ-033 MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIVU A=100 B=7 -> LO=14, HI=2.
REQ-034 DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 DIVU A=5 B=0 with HI=2, LO=14 beforehand -> at edge k+1 done=1, div_by_zero=1, HI=2, LO=14.
REQ-036 Start a MULT, pulse start again at k+5 (ignored), assert reset at k+10 -> after k+10 busy=0, HI=LO=0, no done; a new start then completes normally 33 cycles later.
